// File: rtl/ks_pkg.sv
// Shared types and helpers for the 128x128 carry-less multiplier sequencer.
// Holds the phase encoding, widths and the GF(2) combine used by core and bench.
package ks_pkg;

  localparam int HALF = 64;
  localparam int W    = 128;
  localparam int PW   = 256;

  typedef enum logic [2:0] {
    IDLE,
    P_LO,
    P_HI,
    P_MID,
    DONE
  } state_t;

  function automatic logic [63:0] clmul32(
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (y[i]) r = r ^ ({32'b0, x} << i);
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] clmul_combine(
    input logic [W-1:0] t0,
    input logic [W-1:0] t1,
    input logic [W-1:0] t2
  );
    logic [W-1:0] mid;
    mid = t0 ^ t1 ^ t2;
    return {128'b0, t0}
         ^ ({128'b0, mid} << 64)
         ^ {t1, 128'b0};
  endfunction

endpackage

// File: rtl/ks64.sv
// 64x64 carry-less multiplier, one Karatsuba level over 32-bit clmuls.
// Purely combinational; any pipelining lives in the caller.
module ks64 (
  input  logic [63:0]  a,
  input  logic [63:0]  b,
  output logic [127:0] p
);
  import ks_pkg::*;

  logic [63:0] z0;
  logic [63:0] z1;
  logic [63:0] z2;

  always_comb begin
    z0 = clmul32(a[31:0], b[31:0]);
    z2 = clmul32(a[63:32], b[63:32]);
    z1 = clmul32(a[31:0] ^ a[63:32], b[31:0] ^ b[63:32]) ^ z0 ^ z2;
    p  = {z2, z0} ^ ({64'b0, z1} << 32);
  end

endmodule

// File: rtl/ks128_seq.sv
// 128x128 carry-less multiplier: one ks64 core time-shared over
// three Karatsuba phases, valid/ready on both sides.
module ks128_seq #(
  parameter int MUL_LAT = 0,
  parameter int HALF    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*HALF-1:0] a,
  input  logic [2*HALF-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*HALF-1:0] prod,
  output logic              busy
);
  import ks_pkg::*;

  state_t            state_q, state_d;
  logic [2*HALF-1:0] a_q, a_d;
  logic [2*HALF-1:0] b_q, b_d;
  logic [2*HALF-1:0] t0_q, t0_d;
  logic [2*HALF-1:0] t1_q, t1_d;
  logic [2*HALF-1:0] mul_q, mul_d;
  logic [4*HALF-1:0] prod_q, prod_d;
  logic              ov_q, ov_d;
  logic              cnt_q, cnt_d;

  logic [HALF-1:0]   op_a;
  logic [HALF-1:0]   op_b;
  logic [2*HALF-1:0] ks_p;
  logic [2*HALF-1:0] t_cur;
  logic              ph_done;

  ks64 u_ks64 (
    .a (op_a),
    .b (op_b),
    .p (ks_p)
  );

  // Operand selection depends on phase only, zeros outside phases.
  always_comb begin
    op_a = '0;
    op_b = '0;
    unique case (state_q)
      P_LO: begin
        op_a = a_q[HALF-1:0];
        op_b = b_q[HALF-1:0];
      end
      P_HI: begin
        op_a = a_q[2*HALF-1:HALF];
        op_b = b_q[2*HALF-1:HALF];
      end
      P_MID: begin
        op_a = a_q[HALF-1:0] ^ a_q[2*HALF-1:HALF];
        op_b = b_q[HALF-1:0] ^ b_q[2*HALF-1:HALF];
      end
      default: ;
    endcase
  end

  always_comb begin
    mul_d   = ks_p;
    t_cur   = (MUL_LAT == 0) ? ks_p : mul_q;
    ph_done = (MUL_LAT == 0) ? 1'b1 : cnt_q;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    prod_d  = prod_q;
    ov_d    = ov_q;
    cnt_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = P_LO;
        end
      end
      P_LO: begin
        if (ph_done) begin
          t0_d    = t_cur;
          state_d = P_HI;
        end else begin
          cnt_d = 1'b1;
        end
      end
      P_HI: begin
        if (ph_done) begin
          t1_d    = t_cur;
          state_d = P_MID;
        end else begin
          cnt_d = 1'b1;
        end
      end
      P_MID: begin
        if (ph_done) begin
          prod_d  = clmul_combine(t0_q, t1_q, t_cur);
          ov_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      mul_q   <= '0;
      prod_q  <= '0;
      ov_q    <= 1'b0;
      cnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      mul_q   <= mul_d;
      prod_q  <= prod_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = ov_q;
  assign prod      = prod_q;

endmodule
